// File: rtl/dsc_pkg.sv
// dsc_pkg: shared types, sizing helpers and saturation for the DSC datapath
package dsc_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  localparam int DEF_NUM_BITS = 6;
  localparam int DEF_NUM_INPUTS = 2;
  function automatic int out_w(input int nb, input int ni);
    return nb * ni;
  endfunction
  function automatic int frame_len(input int w);
    return 2 ** w;
  endfunction
  // A full frame of ones would need one bit more than the result carries.
  function automatic logic [31:0] saturate(input logic [31:0] v, input int w);
    return (v >= 32'(frame_len(w))) ? 32'(frame_len(w) - 1) : v;
  endfunction
endpackage

// File: rtl/dsc_counter.sv
// dsc_counter: up-counter with synchronous clear that can count in the clear cycle
module dsc_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk)
    if (!rst) r_q <= '0;
    else r_q <= (i_clr ? '0 : r_q) + WIDTH'(i_inc);
  assign o_q = r_q;
endmodule

// File: rtl/dsc_stoch2bin.sv
// dsc_stoch2bin: counts ones of a unipolar stochastic stream over a 2^OUT_W frame
module dsc_stoch2bin
  import dsc_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  localparam int OUT_W = out_w(NUM_BITS, NUM_INPUTS),
  localparam int FRAME_LEN = frame_len(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             sn_in,
  output logic             busy,
  output logic             ov,
  output logic [OUT_W-1:0] z,
  output logic             z_valid,
  input  logic             z_ready,
  output logic             sat
);
  state_t r_state;
  logic [OUT_W:0] w_samples, r_ones, w_ones_fin;
  logic w_begin, w_take, w_last, w_sat;
  // A new frame starts from IDLE, or from HOLD only when the result is taken.
  assign w_begin = start & en & ((r_state == IDLE) | ((r_state == HOLD) & z_ready));
  assign w_take = w_begin | ((r_state == COUNT) & en);
  assign w_last = (r_state == COUNT) & en & (w_samples == (OUT_W+1)'(FRAME_LEN - 1));
  assign w_ones_fin = r_ones + (OUT_W+1)'(sn_in);
  assign w_sat = w_ones_fin == (OUT_W+1)'(FRAME_LEN);
  dsc_counter #(.WIDTH(OUT_W + 1)) u_samples (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_begin),
    .i_inc(w_take),
    .o_q  (w_samples)
  );
  always_ff @(posedge clk)
    if (!rst) r_ones <= '0;
    else r_ones <= (w_begin ? '0 : r_ones) + (OUT_W+1)'(w_take & sn_in);
  always_ff @(posedge clk)
    if (!rst) begin
      r_state <= IDLE;
      busy <= 1'b0;
      ov <= 1'b0;
      z <= '0;
      z_valid <= 1'b0;
      sat <= 1'b0;
    end else begin
      ov <= 1'b0;
      case (r_state)
        IDLE:
          if (w_begin) begin
            r_state <= COUNT;
            busy <= 1'b1;
          end
        COUNT:
          if (w_last) begin
            r_state <= HOLD;
            busy <= 1'b0;
            ov <= 1'b1;
            z_valid <= 1'b1;
            z <= OUT_W'(saturate(32'(w_ones_fin), OUT_W));
            sat <= w_sat;
          end
        HOLD:
          if (z_ready) begin
            z_valid <= 1'b0;
            r_state <= w_begin ? COUNT : IDLE;
            busy <= w_begin;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dsc_stoch2bin.sv
// tb_dsc_stoch2bin: directed frames checked against a queue-based frame model
module tb_dsc_stoch2bin;
  logic clk = 0, rst = 0, en = 0, start = 0, sn_in = 0, z_ready = 0;
  logic busy, ov, z_valid, sat;
  logic [3:0] z;
  int total = 0, bad = 0, ov_total = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  dsc_stoch2bin #(.NUM_BITS(2), .NUM_INPUTS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .sn_in(sn_in),
    .busy(busy), .ov(ov), .z(z), .z_valid(z_valid), .z_ready(z_ready), .sat(sat)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: 0 idle, 1 collecting samples, 2 holding a result
  int m_mode = 0;
  bit m_q[$];
  logic m_busy = 0, m_ov = 0, m_valid = 0, m_sat = 0;
  logic [3:0] m_z = 0;

  always @(posedge clk) begin
    int n;
    bit go;
    m_ov = 0;
    if (!rst) begin
      m_mode = 0; m_q.delete(); m_busy = 0; m_valid = 0; m_z = 0; m_sat = 0;
    end else begin
      go = start && en && (m_mode == 0 || (m_mode == 2 && z_ready));
      if (m_mode == 2 && z_ready) begin m_valid = 0; m_mode = 0; end
      if (go) begin m_q.delete(); m_mode = 1; end
      if (m_mode == 1 && en) m_q.push_back(sn_in);
      if (m_mode == 1 && m_q.size() == 16) begin
        n = 0;
        foreach (m_q[k]) n += int'(m_q[k]);
        m_valid = 1; m_ov = 1; m_sat = (n == 16);
        m_z = m_sat ? 4'd15 : 4'(n);
        m_mode = 2;
      end
      m_busy = (m_mode == 1);
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      chk("m_busy", busy, m_busy);
      chk("m_ov", ov, m_ov);
      chk("m_z_valid", z_valid, m_valid);
      chk("m_z", z, m_z);
      if (m_valid) chk("m_sat", sat, m_sat);
      if (ov === 1'b1) ov_total++;
    end

  task automatic run_frame(input logic [15:0] pat, input int gap_at, input int gap_len,
                           input int start_at, input logic [3:0] ez, input logic es,
                           input string nm);
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) begin
          en = 0; sn_in = 1; start = 0;
          @(negedge clk);
          chk({nm, "_gap_busy"}, busy, 1);
        end
      en = 1; sn_in = pat[i]; start = (i == 0) || (i == start_at);
      @(negedge clk);
      if (i == 14) chk({nm, "_no_early_ov"}, ov, 0);
    end
    start = 0; sn_in = 0;
    chk({nm, "_ov"}, ov, 1);
    chk({nm, "_valid"}, z_valid, 1);
    chk({nm, "_z"}, z, ez);
    chk({nm, "_sat"}, sat, es);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", z_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_sat", sat, 0);
    rst = 1; z_ready = 1;
    @(negedge clk);
    run_frame(16'h5555, -1, 0, -1, 4'd8, 0, "t1");
    @(negedge clk);
    chk("t1_ov_once", ov, 0);
    chk("t1_released", z_valid, 0);
    chk("t1_z_kept", z, 8);
    run_frame(16'hFFFF, -1, 0, -1, 4'd15, 1, "t2_ones");
    @(negedge clk);
    run_frame(16'h0000, -1, 0, -1, 4'd0, 0, "t2_zeros");
    @(negedge clk);
    run_frame(16'h01FF, 8, 5, -1, 4'd9, 0, "t3");
    @(negedge clk);
    z_ready = 0;
    run_frame(16'h1234, -1, 0, -1, 4'd5, 0, "t4a");
    for (int c = 0; c < 10; c++) begin
      start = (c == 3); en = 1;
      @(negedge clk);
      chk("t4_hold_valid", z_valid, 1);
      chk("t4_hold_z", z, 5);
      chk("t4_hold_busy", busy, 0);
    end
    z_ready = 1;
    run_frame(16'h0007, -1, 0, -1, 4'd3, 0, "t4b");
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      en = 1; sn_in = 1; start = (i == 0);
      @(negedge clk);
    end
    start = 0; rst = 0;
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_valid", z_valid, 0);
    chk("t5_z", z, 0);
    chk("t5_ov", ov, 0);
    rst = 1;
    @(negedge clk);
    run_frame(16'h0124, -1, 0, -1, 4'd3, 0, "t5");
    @(negedge clk);
    run_frame(16'hFF00, -1, 0, 5, 4'd8, 0, "t6");
    @(negedge clk);
    chk("t6_ov_once", ov, 0);
    chk("ov_total", ov_total, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsc_stoch2bin.md
Name: dsc_stoch2bin

Overview:
- Stochastic-to-binary decoder: consumes a unipolar deterministic-stochastic bitstream and counts its ones over a fixed frame of 2^OUT_W sampled cycles.
- Returns the binary value through a valid/ready output with a one-frame-done pulse.
- Sits at the output end of the DSC datapath. It is the decode counterpart of the bin-to-stochastic encoders feeding dsc_mul, and is usable standalone or after any DSC arithmetic stage.

Parameters:
- NUM_BITS, 6, width of each binary operand encoded upstream.
- NUM_INPUTS, 2, number of operands combined upstream.
- OUT_W, NUM_INPUTS*NUM_BITS, result width; derived, never overridden.
- FRAME_LEN, 2**OUT_W, sampled cycles per frame; derived.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  sample enable; when low, sampling and the frame count pause.
- start  in  1  frame start request, single-cycle pulse.
- sn_in  in  1  stochastic bit, sampled when en=1 during a frame.
- busy  out  1  high while a frame is being counted.
- ov  out  1  one-cycle pulse when a frame completes.
- z  out  OUT_W  decoded value; held stable while z_valid=1.
- z_valid  out  1  result available.
- z_ready  in  1  consumer accepts z when z_valid & z_ready.
- sat  out  1  result saturated (all FRAME_LEN samples were 1); qualified by z_valid.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; busy=0, ov=0, z=0, z_valid=0, sat=0; all counters cleared. Reset mid-frame or mid-HOLD discards the result immediately, with no ov pulse.
- Internal counters:
  - sample counter, OUT_W+1 bits, counts sampled cycles;
  - ones counter, OUT_W+1 bits, counts ones.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - start & en → COUNT. The start cycle is sample 0: sn_in is counted in that same cycle.
  - start with en=0 is ignored.
- COUNT:
  - busy=1.
  - Each cycle with en=1: sample counter +1, ones counter +sn_in.
  - en=0: both counters hold.
  - start is ignored.
  - When the FRAME_LEN-th sample is taken → HOLD.
- Frame completion (the registered outputs update at the edge of the FRAME_LEN-th sample; all values below are visible in the following cycle):
  - busy=0, ov=1 for exactly that one cycle, z_valid=1.
  - z = ones count, or 2^OUT_W-1 with sat=1 if ones count = FRAME_LEN.
  - Latency: z_valid rises 1 cycle after the last sample edge.
- HOLD:
  - z, sat and z_valid are held until z_valid & z_ready.
  - Handshake without start: → IDLE, z_valid=0; z keeps its last value.
  - Handshake with start & en in the same cycle: back-to-back, → COUNT, and that cycle is sample 0 of the new frame.
  - start without z_ready is ignored; the result is never overwritten.
- z_ready is ignored when z_valid=0.
- Max unsaturated value is 2^OUT_W-1. The product (2^NUM_BITS-1)^NUM_INPUTS from dsc_mul never saturates.

Decomposition:
- Shared package dsc_pkg:
  - state enum {IDLE, COUNT, HOLD};
  - localparam helpers for OUT_W and FRAME_LEN, with NUM_BITS/NUM_INPUTS defaults;
  - a saturate function.
- Sub-module: reuse the existing counter (WIDTH=OUT_W+1) for the sample counter.
- The ones counter and FSM live inline.

Test Plan:
Benches run with NUM_BITS=2, NUM_INPUTS=2 (OUT_W=4, FRAME_LEN=16).
1. Pattern 1010… (8 ones in 16), en=1 throughout, z_ready=1 → ov pulse and z_valid 1 cycle after the 16th sample; z=8, sat=0; ov exactly 1 cycle.
2. All-ones stream → z=15, sat=1. All-zeros stream → z=0, sat=0.
3. en low for 5 cycles mid-frame, sn_in=1 while en low, 9 ones sampled → z=9; completion delayed exactly 5 cycles; busy stays 1 through the gap.
4. Frame done with z_ready=0 for 10 cycles, start pulsed during the hold → z stable and z_valid=1 throughout, start ignored. Then z_ready=1 together with start → back-to-back frame begins, and that cycle is counted as sample 0.
5. rst=0 at sample 7 of a frame → next cycle busy=0, z_valid=0, z=0, no ov. A following frame with 3 ones → z=3.
6. start pulsed during COUNT → no effect: ov fires once at 16 samples, with the correct count.
